// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// FSM state encoding, default width, divide-by-zero quotient.
package div_pkg;

  localparam int DIV_W = 32;

  localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_st_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// in: rem, q, divisor  out: rem_next, q_next
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
  logic           ge;

  assign sh   = {rem, q[WIDTH-1]};
  assign diff = sh - {1'b0, divisor};
  // sh < 2*divisor, so the top bit of diff is a clean borrow
  assign ge   = ~diff[WIDTH];

  assign rem_next = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign q_next   = {q[WIDTH-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit: quotient -> LO, remainder -> HI.
// in: clk reset start is_signed dividend divisor; out: busy done quotient remainder div_by_zero
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_st_t st_q, st_d;

  logic [WIDTH-1:0] rem_q, q_q, dvs_q;
  logic [WIDTH-1:0] q_out, r_out;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg, r_neg;
  logic             dz_q, dz_out;

  logic [WIDTH-1:0] rem_n, q_n;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             bzero;

  assign bzero = (divisor == '0);
  assign a_mag = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .q        (q_q),
    .divisor  (dvs_q),
    .rem_next (rem_n),
    .q_next   (q_n)
  );

  always_ff @(posedge clk) begin
    if (reset) st_q <= IDLE;
    else       st_q <= st_d;
  end

  // A zero divisor enters RUN with cnt=0: one empty cycle, no steps
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (start) st_d = RUN;
      RUN:     if (cnt_q <= CNT_W'(1)) st_d = FIN;
      FIN:     st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // On a zero divisor q_q carries the raw dividend for HI
  assign q_fix = dz_q  ? DIV_ZERO_Q :
                 q_neg ? -q_q : q_q;
  assign r_fix = dz_q  ? q_q :
                 r_neg ? -rem_q : rem_q;

  assign busy        = (st_q != IDLE);
  assign done        = (st_q == FIN);
  assign quotient    = done ? q_fix : q_out;
  assign remainder   = done ? r_fix : r_out;
  assign div_by_zero = done ? dz_q  : dz_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      q_q    <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dz_q   <= 1'b0;
      dz_out <= 1'b0;
      q_out  <= '0;
      r_out  <= '0;
    end else begin
      unique case (st_q)
        IDLE: if (start) begin
          rem_q <= '0;
          dz_q  <= bzero;
          q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg <= is_signed & dividend[WIDTH-1];
          if (bzero) begin
            q_q   <= dividend;
            dvs_q <= '0;
            cnt_q <= '0;
          end else begin
            q_q    <= a_mag;
            dvs_q  <= b_mag;
            cnt_q  <= CNT_W'(WIDTH);
            dz_out <= 1'b0;
          end
        end
        RUN: if (cnt_q != '0) begin
          rem_q <= rem_n;
          q_q   <= q_n;
          cnt_q <= cnt_q - 1'b1;
        end
        FIN: begin
          q_out  <= q_fix;
          r_out  <= r_fix;
          dz_out <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit.
// Checks latency, results, sign rules, zero divisor, ignored starts, reset abort.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle N+1
  task automatic go(input logic s, input logic [31:0] a,
                    input logic [31:0] b);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(inout int k);
    while (!done && k < 45) begin
      tick();
      k++;
    end
  endtask

  task automatic run(input string tag, input logic s,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er,
                     input logic edz, input int elat);
    int k;
    logic b1;
    go(s, a, b);
    k  = 1;
    b1 = busy;
    wait_done(k);
    chk({tag, ".busy1"}, {31'd0, b1}, 32'd1);
    chk({tag, ".lat"}, k, elat);
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    tick();
    chk({tag, ".done1"}, {31'd0, done}, 32'd0);
    chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    chk({tag, ".hold"}, quotient, eq);
  endtask

  initial begin
    int k;
    int seen;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.q", quotient, 32'd0);
    chk("rst.r", remainder, 32'd0);
    chk("rst.dz", {31'd0, div_by_zero}, 32'd0);

    run("divu100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run("div-100_7", 1'b1, 32'hFFFFFF9C, 32'd7,
        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33);
    run("div100_-7", 1'b1, 32'd100, 32'hFFFFFFF9,
        32'hFFFFFFF2, 32'd2, 1'b0, 33);
    run("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
        32'h80000000, 32'd0, 1'b0, 33);
    run("divu_max", 1'b0, 32'hFFFFFFFF, 32'd1,
        32'hFFFFFFFF, 32'd0, 1'b0, 33);
    run("divu_big", 1'b0, 32'hFFFFFFFF, 32'h80000001,
        32'd1, 32'h7FFFFFFE, 1'b0, 33);

    run("dz", 1'b0, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, 2);
    chk("dz.sticky", {31'd0, div_by_zero}, 32'd1);
    go(1'b0, 32'd9, 32'd3);
    chk("dz.clear", {31'd0, div_by_zero}, 32'd0);
    k = 1;
    wait_done(k);
    chk("dz.next.q", quotient, 32'd3);
    chk("dz.next.r", remainder, 32'd0);
    tick();

    // second start mid-run must be ignored
    go(1'b0, 32'd50, 32'd5);
    k = 1;
    while (!done && k < 45) begin
      if (k == 9) begin
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    chk("ign.lat", k, 33);
    chk("ign.q", quotient, 32'd10);
    chk("ign.r", remainder, 32'd0);
    // start during the done cycle is not accepted
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("ign.fin.busy", {31'd0, busy}, 32'd0);
    tick();
    chk("ign.fin.busy2", {31'd0, busy}, 32'd0);
    chk("ign.fin.q", quotient, 32'd10);

    // reset aborts an operation in flight
    go(1'b0, 32'd1000, 32'd3);
    repeat (13) tick();
    chk("abort.busy0", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.q", quotient, 32'd0);
    chk("abort.r", remainder, 32'd0);
    chk("abort.dz", {31'd0, div_by_zero}, 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) seen++;
    end
    chk("abort.nodone", seen, 0);
    run("after_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
